// File: rtl/decode_instruction_buffer.sv
// In-order instruction buffer between fetch and decode: captures fetched
// instructions and presents the oldest one as the decode packet.
module decode_instruction_buffer #(
    parameter int DEPTH   = 4,
    parameter int ID_W    = 3,
    parameter int ECODE_W = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [31:0]                fetch_pc,
    input  logic [31:0]                fetch_instruction,
    input  logic                       fetch_ok,
    input  logic [ECODE_W-1:0]         fetch_error_code,
    input  logic [ID_W-1:0]            fetch_id,
    output logic                       decode_valid,
    output logic [31:0]                decode_pc,
    output logic [31:0]                decode_instruction,
    output logic                       decode_ok,
    output logic [ECODE_W-1:0]         decode_error_code,
    output logic [ID_W-1:0]            decode_id,
    input  logic                       decode_advance,
    input  logic                       fetch_flush,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow_error
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        instr;
        logic               ok;
        logic [ECODE_W-1:0] ecode;
        logic [ID_W-1:0]    id;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    logic   w_ready;
    logic   w_nonempty;
    logic   w_push;
    logic   w_pop;
    entry_t w_wr_entry;
    entry_t w_head;

    // Ready depends only on registered count, so a same-cycle pop never
    // opens a slot for a push.
    assign w_ready    = (r_count < FULL_CNT);
    assign w_nonempty = (r_count != '0);
    assign w_push     = fetch_valid & w_ready & ~fetch_flush;
    assign w_pop      = decode_advance & w_nonempty & ~fetch_flush;

    assign w_wr_entry = '{pc:    fetch_pc,
                          instr: fetch_instruction,
                          ok:    fetch_ok,
                          ecode: fetch_error_code,
                          id:    fetch_id};

    // Payload storage carries no reset; outputs are qualified by decode_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (fetch_valid & ~w_ready & ~fetch_flush) begin
                r_overflow <= 1'b1;
            end
            if (fetch_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head = r_mem[r_rd_ptr];

    assign fetch_ready        = w_ready;
    assign decode_valid       = w_nonempty;
    assign decode_pc          = w_head.pc;
    assign decode_instruction = w_head.instr;
    assign decode_ok          = w_head.ok;
    assign decode_error_code  = w_head.ecode;
    assign decode_id          = w_head.id;
    assign occupancy          = r_count;
    assign overflow_error     = r_overflow;
endmodule

// File: tb/tb_decode_instruction_buffer.sv
// Bench for decode_instruction_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_decode_instruction_buffer;
    localparam int DEPTH   = 4;
    localparam int ID_W    = 3;
    localparam int ECODE_W = 5;

    logic                 clk;
    logic                 rst;
    logic                 fetch_valid;
    logic                 fetch_ready;
    logic [31:0]          fetch_pc;
    logic [31:0]          fetch_instruction;
    logic                 fetch_ok;
    logic [ECODE_W-1:0]   fetch_error_code;
    logic [ID_W-1:0]      fetch_id;
    logic                 decode_valid;
    logic [31:0]          decode_pc;
    logic [31:0]          decode_instruction;
    logic                 decode_ok;
    logic [ECODE_W-1:0]   decode_error_code;
    logic [ID_W-1:0]      decode_id;
    logic                 decode_advance;
    logic                 fetch_flush;
    logic [$clog2(DEPTH):0] occupancy;
    logic                 overflow_error;

    decode_instruction_buffer #(.DEPTH(DEPTH), .ID_W(ID_W), .ECODE_W(ECODE_W)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_instruction(fetch_instruction),
        .fetch_ok(fetch_ok), .fetch_error_code(fetch_error_code), .fetch_id(fetch_id),
        .decode_valid(decode_valid), .decode_pc(decode_pc),
        .decode_instruction(decode_instruction), .decode_ok(decode_ok),
        .decode_error_code(decode_error_code), .decode_id(decode_id),
        .decode_advance(decode_advance), .fetch_flush(fetch_flush),
        .occupancy(occupancy), .overflow_error(overflow_error)
    );

    typedef struct {
        logic [31:0]        pc;
        logic [31:0]        instr;
        logic               ok;
        logic [ECODE_W-1:0] ec;
        logic [ID_W-1:0]    id;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, advance the reference model, cross the edge.
    task automatic step(input logic fv, input logic [31:0] pc, input logic [ID_W-1:0] id,
                        input logic ok, input logic [ECODE_W-1:0] ec,
                        input logic adv, input logic fl);
        ent_t e;
        bit   full_before;
        bit   do_push;
        bit   do_pop;
        fetch_valid       = fv;
        fetch_pc          = pc;
        fetch_instruction = $urandom;
        fetch_ok          = ok;
        fetch_error_code  = ec;
        fetch_id          = id;
        decode_advance    = adv;
        fetch_flush       = fl;
        full_before = (mq.size() >= DEPTH);
        do_push = fv && !full_before && !fl;
        do_pop  = adv && (mq.size() > 0) && !fl;
        if (fv && full_before && !fl) m_ovf = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.pc = pc; e.instr = fetch_instruction; e.ok = ok; e.ec = ec; e.id = id;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, '0, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [ID_W-1:0] id);
        step(1'b1, pc, id, 1'b1, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fetch_valid = 1'b0; decode_advance = 1'b0; fetch_flush = 1'b0;
        fetch_pc = '0; fetch_instruction = '0; fetch_ok = 1'b1;
        fetch_error_code = '0; fetch_id = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({decode_valid, fetch_ready, occupancy, overflow_error} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b occ=%0d ovf=%b, required 0 1 0 0",
                     decode_valid, fetch_ready, occupancy, overflow_error);
        end
    endtask

    task automatic test_basic_push();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(32'h100 + 32'(4 * i), ID_W'(i));
            checks++;
            if (decode_valid !== 1'b1 || decode_pc !== 32'h100 || decode_id !== '0 ||
                occupancy !== 3'(i + 1)) begin
                errors++;
                $display("FAIL basic_push[%0d]: valid=%b pc=%h id=%0d occ=%0d, required 1 100 0 %0d",
                         i, decode_valid, decode_pc, decode_id, occupancy, i + 1);
            end
        end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h200 + 32'(4 * i), ID_W'(i));
        checks++;
        if (occupancy !== 3'd4 || fetch_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill: occ=%0d ready=%b, required 4 0", occupancy, fetch_ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (decode_valid !== 1'b1 || decode_pc !== 32'h200 + 32'(4 * i) || decode_id !== ID_W'(i)) begin
                errors++;
                $display("FAIL drain[%0d]: valid=%b pc=%h id=%0d, required 1 %h %0d",
                         i, decode_valid, decode_pc, decode_id, 32'h200 + 32'(4 * i), i);
            end
            step(1'b0, 32'h0, '0, 1'b1, '0, 1'b1, 1'b0);
        end
        checks++;
        if (decode_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b occ=%0d, required 0 0", decode_valid, occupancy);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'h600 + 32'(4 * i), ID_W'(i));
        step(1'b1, 32'h700, 3'd7, 1'b1, '0, 1'b1, 1'b0);
        checks++;
        if (occupancy !== 3'd3 || decode_pc !== 32'h604 || overflow_error !== 1'b1 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: occ=%0d pc=%h ovf=%b ready=%b, required 3 604 1 1",
                     occupancy, decode_pc, overflow_error, fetch_ready);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, '0, 1'b1, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        checks++;
        if (decode_valid !== 1'b0 || overflow_error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: valid=%b ovf=%b, required 0 1", decode_valid, overflow_error);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] last;
        do_reset();
        push(32'h300, 3'd0);
        push(32'h304, 3'd1);
        last = decode_pc;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h308 + 32'(4 * i), ID_W'(i + 2), 1'b1, '0, 1'b1, 1'b0);
            checks++;
            if (occupancy !== 3'd2 || decode_pc <= last || decode_pc !== 32'h304 + 32'(4 * i)) begin
                errors++;
                $display("FAIL wrap[%0d]: occ=%0d pc=%h, required 2 %h", i, occupancy, decode_pc,
                         32'h304 + 32'(4 * i));
            end
            last = decode_pc;
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) push(32'h380 + 32'(4 * i), ID_W'(i));
        step(1'b1, 32'h3F0, 3'd5, 1'b1, '0, 1'b1, 1'b1);
        checks++;
        if (decode_valid !== 1'b0 || occupancy !== 3'd0 || fetch_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: valid=%b occ=%0d ready=%b, required 0 0 1",
                     decode_valid, occupancy, fetch_ready);
        end
        // Push into an empty buffer while advance is asserted: pop is ignored.
        step(1'b1, 32'h400, 3'd6, 1'b1, '0, 1'b1, 1'b0);
        checks++;
        if (decode_valid !== 1'b1 || decode_pc !== 32'h400 || decode_id !== 3'd6 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL after_flush: valid=%b pc=%h id=%0d occ=%0d, required 1 400 6 1",
                     decode_valid, decode_pc, decode_id, occupancy);
        end
    endtask

    task automatic test_error_meta();
        do_reset();
        step(1'b1, 32'h500, 3'd2, 1'b0, 5'd1, 1'b0, 1'b0);
        push(32'h504, 3'd3);
        checks++;
        if (decode_ok !== 1'b0 || decode_error_code !== 5'd1 || decode_pc !== 32'h500) begin
            errors++;
            $display("FAIL err_head: ok=%b ec=%0d pc=%h, required 0 1 500",
                     decode_ok, decode_error_code, decode_pc);
        end
        step(1'b0, 32'h0, '0, 1'b1, '0, 1'b1, 1'b0);
        checks++;
        if (decode_ok !== 1'b1 || decode_pc !== 32'h504 || decode_id !== 3'd3) begin
            errors++;
            $display("FAIL err_next: ok=%b pc=%h id=%0d, required 1 504 3", decode_ok, decode_pc, decode_id);
        end
    endtask

    task automatic test_random();
        logic fv, adv, fl;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            fv  = ($urandom_range(0, 99) < 60);
            adv = ($urandom_range(0, 99) < 50);
            fl  = ($urandom_range(0, 99) < 4);
            step(fv, $urandom, ID_W'($urandom), 1'($urandom), ECODE_W'($urandom), adv, fl);
            checks++;
            if (decode_valid !== (mq.size() != 0) || occupancy !== 3'(mq.size()) ||
                fetch_ready !== (mq.size() < DEPTH) || overflow_error !== m_ovf) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: valid=%b occ=%0d ready=%b ovf=%b, required %b %0d %b %b",
                         i, decode_valid, occupancy, fetch_ready, overflow_error,
                         mq.size() != 0, mq.size(), mq.size() < DEPTH, m_ovf);
            end
            if (mq.size() != 0) begin
                checks++;
                if (decode_pc !== mq[0].pc || decode_instruction !== mq[0].instr ||
                    decode_ok !== mq[0].ok || decode_error_code !== mq[0].ec || decode_id !== mq[0].id) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: pc=%h ins=%h ok=%b ec=%0d id=%0d, required %h %h %b %0d %0d",
                             i, decode_pc, decode_instruction, decode_ok, decode_error_code, decode_id,
                             mq[0].pc, mq[0].instr, mq[0].ok, mq[0].ec, mq[0].id);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_push();
        test_fill_drain();
        test_full_pop();
        test_reset();
        test_wrap();
        test_flush();
        test_error_meta();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
